// File: rtl/seg7_scan_driver_if.sv
// Scan-driver signal bundle: scan clock and display data in, anode/cathode drive out.
// master = the scan driver itself, slave = the board/bench side.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    clk_1khz;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp;
  logic                    frame_start;

  modport master (
    input  clk_1khz, digits, dp_in,
    output an, seg, dp, frame_start
  );

  modport slave (
    output clk_1khz, digits, dp_in,
    input  an, seg, dp, frame_start
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver with inter-digit blanking and per-frame value latching.
// Optional leading-zero blanking is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 8
) (
  input  logic               clk_in,
  input  logic               rst,
  seg7_scan_driver_if.master bus
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic {S_BLANK = 1'b0, S_DRIVE = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    clk_1khz_q;
  logic                    tick;
  logic                    load_frame;
  logic                    load_q;
  logic [4*NUM_DIGITS-1:0] shadow_dig_q;
  logic [NUM_DIGITS-1:0]   shadow_dp_q;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    frame_start_q;
  logic [3:0]              dig_arr [NUM_DIGITS];

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'h0: seg_decode = 7'h40;
      4'h1: seg_decode = 7'h79;
      4'h2: seg_decode = 7'h24;
      4'h3: seg_decode = 7'h30;
      4'h4: seg_decode = 7'h19;
      4'h5: seg_decode = 7'h12;
      4'h6: seg_decode = 7'h02;
      4'h7: seg_decode = 7'h78;
      4'h8: seg_decode = 7'h00;
      4'h9: seg_decode = 7'h10;
      4'hA: seg_decode = 7'h08;
      4'hB: seg_decode = 7'h03;
      4'hC: seg_decode = 7'h46;
      4'hD: seg_decode = 7'h21;
      4'hE: seg_decode = 7'h06;
      default: seg_decode = 7'h0E;
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
      assign dig_arr[gi] = shadow_dig_q[4*gi +: 4];
    end
  endgenerate

  assign tick       = bus.clk_1khz & ~clk_1khz_q;
  // The shadow is refreshed only when digit 0 is about to be driven, so a frame never tears.
  assign load_frame = (state_q == S_BLANK) && (cnt_q == LAST_CNT) && (idx_q == '0);

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) state_q <= S_BLANK;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_BLANK: begin
        if (cnt_q == LAST_CNT) begin
          state_d = S_DRIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (tick) begin
          state_d = S_BLANK;
          idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
      end
    endcase
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] hi_idx;
  always_comb begin
    hi_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_arr[i] != 4'h0) hi_idx = IDX_W'(i);
    end
  end
`endif

  // Outputs are computed from the current state and registered, so they trail state by one cycle.
  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (state_q == S_DRIVE) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = seg_decode(dig_arr[idx_q]);
      dp_d  = ~shadow_dp_q[idx_q];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (idx_q > hi_idx) seg_d = 7'h7F;
`endif
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      idx_q         <= '0;
      cnt_q         <= '0;
      clk_1khz_q    <= 1'b0;
      load_q        <= 1'b0;
      shadow_dig_q  <= '0;
      shadow_dp_q   <= '0;
      an_q          <= '1;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      clk_1khz_q    <= bus.clk_1khz;
      load_q        <= load_frame;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= load_q;
      if (load_frame) begin
        shadow_dig_q <= bus.digits;
        shadow_dp_q  <= bus.dp_in;
      end
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized self-checking bench for seg7_scan_driver against a frame-level display model.
// Expectations follow SEG7_LEADING_ZERO_BLANK_EN when it is defined for the build.
module tb_seg7_scan_driver;
  localparam int N  = 4;
  localparam int BC = 8;
  localparam logic [6:0] SEG_TBL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic clk_in = 1'b0;
  logic rst    = 1'b0;

  seg7_scan_driver_if #(.NUM_DIGITS(N)) bus ();

  seg7_scan_driver #(.NUM_DIGITS(N), .BLANK_CYCLES(BC)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          m_idx = 0;
  logic [15:0] m_dig = '0;
  logic [3:0]  m_dp = '0;
  int          last_blanks;
  bit          last_to;

  // Displayed pattern for digit i of a latched frame.
  function automatic logic [6:0] exp_seg(input logic [15:0] fd, input int i);
    logic [3:0] v;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    int hi;
    hi = 0;
    for (int k = 0; k < N; k++) if (fd[4*k +: 4] != 4'h0) hi = k;
    if (i > hi) return 7'h7F;
`endif
    v = fd[4*i +: 4];
    return SEG_TBL[v];
  endfunction

  function automatic logic [3:0] exp_an(input int i);
    logic [3:0] a;
    a = 4'hF;
    a[i] = 1'b0;
    return a;
  endfunction

  task automatic pulse_tick();
    @(negedge clk_in);
    bus.clk_1khz = 1'b1;
    @(negedge clk_in);
    bus.clk_1khz = 1'b0;
  endtask

  task automatic wait_lit(output int blanks, output bit to);
    bit done;
    blanks = 0;
    done   = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk_in);
      if (bus.an !== 4'hF) done = 1'b1;
      else blanks++;
    end
    to = !done;
  endtask

  // One scan step: tick, model advances (latching inputs on wrap), wait for next lit digit.
  task automatic advance();
    pulse_tick();
    m_idx = (m_idx + 1) % N;
    if (m_idx == 0) begin
      m_dig = bus.digits;
      m_dp  = bus.dp_in;
    end
    wait_lit(last_blanks, last_to);
    $display("digit %0d an=%b seg=%h dp=%b frame_start=%b blanks=%0d",
             m_idx, bus.an, bus.seg, bus.dp, bus.frame_start, last_blanks);
  endtask

  task automatic test_reset();
    int k;
    bus.clk_1khz = 1'b0;
    bus.digits   = 16'h1234;
    bus.dp_in    = 4'h0;
    rst          = 1'b0;
    repeat (3) @(negedge clk_in);
    total_cnt += 4;
    if (bus.an !== 4'hF) $display("FAIL reset_an: got %b expected 1111", bus.an); else pass_cnt++;
    if (bus.seg !== 7'h7F) $display("FAIL reset_seg: got %h expected 7f", bus.seg); else pass_cnt++;
    if (bus.dp !== 1'b1) $display("FAIL reset_dp: got %b expected 1", bus.dp); else pass_cnt++;
    if (bus.frame_start !== 1'b0) $display("FAIL reset_fs: got %b expected 0", bus.frame_start); else pass_cnt++;
    rst = 1'b1;
    k = 0;
    while (k < 40 && bus.an === 4'hF) begin
      @(posedge clk_in);
      #1;
      k++;
    end
    m_idx = 0; m_dig = 16'h1234; m_dp = 4'h0;
    $display("reset released: first lit on edge %0d an=%b seg=%h", k, bus.an, bus.seg);
    total_cnt += 5;
    if (k !== BC + 1) $display("FAIL first_lit_edge: got %0d expected %0d", k, BC + 1); else pass_cnt++;
    if (bus.an !== 4'b1110) $display("FAIL first_an: got %b expected 1110", bus.an); else pass_cnt++;
    if (bus.seg !== 7'h19) $display("FAIL first_seg: got %h expected 19", bus.seg); else pass_cnt++;
    if (bus.frame_start !== 1'b1) $display("FAIL first_fs: got %b expected 1", bus.frame_start); else pass_cnt++;
    @(posedge clk_in);
    #1;
    if (bus.frame_start !== 1'b0) $display("FAIL fs_one_cycle: got %b expected 0", bus.frame_start); else pass_cnt++;
    @(negedge clk_in);
  endtask

  // Steps through 1234 first, then random values changed at arbitrary points of the frame.
  task automatic test_scan();
    for (int step = 0; step < 19; step++) begin
      if (step >= 3) begin
        bus.digits = 16'($urandom >> (4 * $urandom_range(0, 4)));
        bus.dp_in  = 4'($urandom);
      end
      repeat ($urandom_range(0, 4)) @(negedge clk_in);
      advance();
      total_cnt += 6;
      if (last_to) $display("FAIL scan_timeout: got timeout expected lit digit %0d", m_idx); else pass_cnt++;
      if (last_blanks !== BC) $display("FAIL scan_blanks: got %0d expected %0d", last_blanks, BC); else pass_cnt++;
      if (bus.an !== exp_an(m_idx)) $display("FAIL scan_an: got %b expected %b", bus.an, exp_an(m_idx)); else pass_cnt++;
      if (bus.seg !== exp_seg(m_dig, m_idx))
        $display("FAIL scan_seg: got %h expected %h (digit %0d frame %h)", bus.seg, exp_seg(m_dig, m_idx), m_idx, m_dig);
      else pass_cnt++;
      if (bus.dp !== ~m_dp[m_idx]) $display("FAIL scan_dp: got %b expected %b", bus.dp, ~m_dp[m_idx]); else pass_cnt++;
      if (bus.frame_start !== (m_idx == 0))
        $display("FAIL scan_fs: got %b expected %b", bus.frame_start, (m_idx == 0));
      else pass_cnt++;
    end
  endtask

  task automatic test_tear();
    bus.digits = 16'h1234;
    bus.dp_in  = 4'h0;
    do advance(); while (m_idx != 0);
    advance();
    bus.digits = 16'hABCD;
    advance();
    total_cnt += 2;
    if (bus.an !== 4'b1011) $display("FAIL tear_an2: got %b expected 1011", bus.an); else pass_cnt++;
    if (bus.seg !== 7'h24) $display("FAIL tear_seg2: got %h expected 24", bus.seg); else pass_cnt++;
    advance();
    total_cnt += 1;
    if (bus.seg !== 7'h79) $display("FAIL tear_seg3: got %h expected 79", bus.seg); else pass_cnt++;
    advance();
    total_cnt += 3;
    if (bus.an !== 4'b1110) $display("FAIL tear_an0: got %b expected 1110", bus.an); else pass_cnt++;
    if (bus.seg !== 7'h21) $display("FAIL tear_seg0: got %h expected 21", bus.seg); else pass_cnt++;
    if (bus.frame_start !== 1'b1) $display("FAIL tear_fs: got %b expected 1", bus.frame_start); else pass_cnt++;
  endtask

  task automatic test_blank_tick();
    pulse_tick();
    m_idx = (m_idx + 1) % N;
    if (m_idx == 0) begin
      m_dig = bus.digits;
      m_dp  = bus.dp_in;
    end
    @(negedge clk_in);
    bus.clk_1khz = 1'b1;
    @(negedge clk_in);
    bus.clk_1khz = 1'b0;
    wait_lit(last_blanks, last_to);
    $display("digit %0d an=%b seg=%h after tick in blank", m_idx, bus.an, bus.seg);
    total_cnt += 3;
    if (last_to) $display("FAIL blank_tick_timeout: got timeout expected lit digit"); else pass_cnt++;
    if (bus.an !== exp_an(m_idx)) $display("FAIL blank_tick_an: got %b expected %b", bus.an, exp_an(m_idx)); else pass_cnt++;
    if (bus.seg !== exp_seg(m_dig, m_idx))
      $display("FAIL blank_tick_seg: got %h expected %h", bus.seg, exp_seg(m_dig, m_idx));
    else pass_cnt++;
    advance();
    total_cnt += 1;
    if (bus.an !== exp_an(m_idx)) $display("FAIL blank_tick_next_an: got %b expected %b", bus.an, exp_an(m_idx)); else pass_cnt++;
  endtask

  task automatic test_zero();
    logic [6:0] want [4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    want = '{7'h40, 7'h12, 7'h7F, 7'h7F};
`else
    want = '{7'h40, 7'h12, 7'h40, 7'h40};
`endif
    bus.digits = 16'h0050;
    bus.dp_in  = 4'h0;
    do advance(); while (m_idx != 0);
    for (int i = 0; i < N; i++) begin
      if (i > 0) advance();
      total_cnt += 2;
      if (bus.an !== exp_an(i)) $display("FAIL zero_an%0d: got %b expected %b", i, bus.an, exp_an(i)); else pass_cnt++;
      if (bus.seg !== want[i]) $display("FAIL zero_seg%0d: got %h expected %h", i, bus.seg, want[i]); else pass_cnt++;
    end
    bus.digits = 16'h0000;
    advance();
    total_cnt += 1;
    if (bus.seg !== 7'h40) $display("FAIL allzero_seg0: got %h expected 40", bus.seg); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int k;
    bus.digits = 16'h5A7E;
    bus.dp_in  = 4'b0001;
    while (m_idx != 2) advance();
    #2;
    rst = 1'b0;
    #1;
    total_cnt += 5;
    if (bus.an !== 4'hF) $display("FAIL midrst_an: got %b expected 1111", bus.an); else pass_cnt++;
    if (bus.seg !== 7'h7F) $display("FAIL midrst_seg: got %h expected 7f", bus.seg); else pass_cnt++;
    if (bus.dp !== 1'b1) $display("FAIL midrst_dp: got %b expected 1", bus.dp); else pass_cnt++;
    @(negedge clk_in);
    rst = 1'b1;
    k = 0;
    while (k < 40 && bus.an === 4'hF) begin
      @(posedge clk_in);
      #1;
      k++;
    end
    $display("mid reset released: first lit on edge %0d an=%b seg=%h dp=%b", k, bus.an, bus.seg, bus.dp);
    if (k !== BC + 1) $display("FAIL midrst_edge: got %0d expected %0d", k, BC + 1); else pass_cnt++;
    if (bus.an !== 4'b1110) $display("FAIL midrst_an0: got %b expected 1110", bus.an); else pass_cnt++;
    total_cnt += 2;
    if (bus.seg !== 7'h06) $display("FAIL midrst_seg0: got %h expected 06", bus.seg); else pass_cnt++;
    if (bus.dp !== 1'b0) $display("FAIL midrst_dp0: got %b expected 0", bus.dp); else pass_cnt++;
    @(negedge clk_in);
  endtask

  initial begin
    bus.clk_1khz = 1'b0;
    bus.digits   = '0;
    bus.dp_in    = '0;
    test_reset();
    test_scan();
    test_tear();
    test_blank_tick();
    test_zero();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
